// File: rtl/alu_pipe_pkg.sv
// Shared constants and types for alu_pipe: mode, select codes, multiplier states.
// The multiplier is built only when ALU_PIPE_MUL_EN is defined.
package alu_pipe_pkg;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Logic-mode function codes
    localparam logic [3:0] LOG_NOT_A      = 4'd0;
    localparam logic [3:0] LOG_NOR        = 4'd1;
    localparam logic [3:0] LOG_NOTA_AND_B = 4'd2;
    localparam logic [3:0] LOG_ZERO       = 4'd3;
    localparam logic [3:0] LOG_NAND       = 4'd4;
    localparam logic [3:0] LOG_NOT_B      = 4'd5;
    localparam logic [3:0] LOG_XOR        = 4'd6;
    localparam logic [3:0] LOG_A_AND_NOTB = 4'd7;
    localparam logic [3:0] LOG_NOTA_OR_B  = 4'd8;
    localparam logic [3:0] LOG_XNOR       = 4'd9;
    localparam logic [3:0] LOG_B          = 4'd10;
    localparam logic [3:0] LOG_AND        = 4'd11;
    localparam logic [3:0] LOG_ONES       = 4'd12;
    localparam logic [3:0] LOG_A_OR_NOTB  = 4'd13;
    localparam logic [3:0] LOG_OR         = 4'd14;
    localparam logic [3:0] LOG_A          = 4'd15;

    // Arithmetic-mode function codes
    localparam logic [3:0] ARI_A_PLUS_C     = 4'd0;
    localparam logic [3:0] ARI_ADD          = 4'd1;
    localparam logic [3:0] ARI_SUB          = 4'd2;
    localparam logic [3:0] ARI_RSUB         = 4'd3;
    localparam logic [3:0] ARI_DBL          = 4'd4;
    localparam logic [3:0] ARI_A_PLUS_AND   = 4'd5;
    localparam logic [3:0] ARI_OR_PLUS_AND  = 4'd6;
    localparam logic [3:0] ARI_A_MINUS_C    = 4'd7;
    localparam logic [3:0] ARI_SHR          = 4'd8;
    localparam logic [3:0] ARI_INC          = 4'd9;
    localparam logic [3:0] ARI_DEC          = 4'd10;
    localparam logic [3:0] ARI_B_PLUS_C     = 4'd11;
    localparam logic [3:0] ARI_NEG          = 4'd12;
    localparam logic [3:0] ARI_A_PLUS_NB    = 4'd13;
    localparam logic [3:0] ARI_ANDN_MINUS_C = 4'd14;
    localparam logic [3:0] ARI_MUL          = 4'd15;

    typedef enum logic [1:0] {
        MUL_S_IDLE = 2'd0,
        MUL_S_MUL  = 2'd1,
        MUL_S_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Shift-add unsigned multiplier: IDLE -> MUL (WIDTH steps) -> DONE -> IDLE.
// Used by alu_pipe only when ALU_PIPE_MUL_EN is defined.
module alu_pipe_mul
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy_c,
    output logic             done_c,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    mul_state_e       state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state: one partial product per MUL cycle, DONE presents the product
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            MUL_S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = MUL_S_MUL;
                end
            end
            MUL_S_MUL: begin
                busy_c = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MUL_S_DONE;
                end
            end
            MUL_S_DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = MUL_S_IDLE;
            end
            default: state_d = MUL_S_IDLE;
        endcase
    end

    assign prod_lo    = acc_q[WIDTH-1:0];
    assign prod_hi_nz = |acc_q[PW-1:WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and a stored carry flag.
// Define ALU_PIPE_MUL_EN to turn arithmetic select 15 into a multi-cycle A*B.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CMP_SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       select,
    input  logic             mode,
    input  logic             carry_in,
    input  logic             use_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             compare,
    output logic             less,
    output logic             zero,
    output logic             busy
);
    localparam int unsigned W1 = WIDTH + 1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             carry_out_q, carry_out_d;
    logic             compare_q, compare_d;
    logic             less_q, less_d;
    logic             zero_q, zero_d;
    logic             carry_flag_q, carry_flag_d;

    logic             cin_c, op_c, op_sub, cout_c, cmp_c, less_c, accept_c, load_c;
    logic [WIDTH-1:0] op_x, op_y, logic_c, res_c;
    logic [WIDTH:0]   arith_c;

    assign accept_c = in_valid && in_ready;
    assign in_ready = !busy && (!out_valid_q || out_ready);
    assign cmp_c    = (in_a == in_b);
    assign less_c   = (CMP_SIGNED != 0) ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

    // Function unit: logic table, or arithmetic as one add/subtract of W+1 bits
    always_comb begin : alu_calc
        cin_c   = use_flag ? carry_flag_q : carry_in;
        op_x    = in_a;
        op_y    = '0;
        op_c    = cin_c;
        op_sub  = 1'b0;
        logic_c = '0;
        case (select)
            LOG_NOT_A:      logic_c = ~in_a;
            LOG_NOR:        logic_c = ~(in_a | in_b);
            LOG_NOTA_AND_B: logic_c = ~in_a & in_b;
            LOG_ZERO:       logic_c = '0;
            LOG_NAND:       logic_c = ~(in_a & in_b);
            LOG_NOT_B:      logic_c = ~in_b;
            LOG_XOR:        logic_c = in_a ^ in_b;
            LOG_A_AND_NOTB: logic_c = in_a & ~in_b;
            LOG_NOTA_OR_B:  logic_c = ~in_a | in_b;
            LOG_XNOR:       logic_c = ~(in_a ^ in_b);
            LOG_B:          logic_c = in_b;
            LOG_AND:        logic_c = in_a & in_b;
            LOG_ONES:       logic_c = '1;
            LOG_A_OR_NOTB:  logic_c = in_a | ~in_b;
            LOG_OR:         logic_c = in_a | in_b;
            default:        logic_c = in_a;
        endcase
        case (select)
            ARI_A_PLUS_C:     ;
            ARI_ADD:          op_y = in_b;
            ARI_SUB:          begin op_y = in_b; op_sub = 1'b1; end
            ARI_RSUB:         begin op_x = in_b; op_y = in_a; op_sub = 1'b1; end
            ARI_DBL:          op_y = in_a;
            ARI_A_PLUS_AND:   op_y = in_a & in_b;
            ARI_OR_PLUS_AND:  begin op_x = in_a | in_b; op_y = in_a & in_b; end
            ARI_A_MINUS_C:    op_sub = 1'b1;
            ARI_SHR:          ;
            ARI_INC:          op_c = 1'b1;
            ARI_DEC:          begin op_c = 1'b1; op_sub = 1'b1; end
            ARI_B_PLUS_C:     op_x = in_b;
            ARI_NEG:          begin op_x = '0; op_y = in_a; op_c = 1'b0; op_sub = 1'b1; end
            ARI_A_PLUS_NB:    op_y = ~in_b;
            ARI_ANDN_MINUS_C: begin op_x = in_a & ~in_b; op_sub = 1'b1; end
            default:          op_sub = 1'b1;  // A-cin; replaced by the multiplier when enabled
        endcase
        if (op_sub) begin
            arith_c = {1'b0, op_x} - {1'b0, op_y} - W1'(op_c);
        end else begin
            arith_c = {1'b0, op_x} + {1'b0, op_y} + W1'(op_c);
        end
        if (mode == MODE_LOGIC) begin
            res_c  = logic_c;
            cout_c = 1'b0;
        end else if (select == ARI_SHR) begin
            res_c  = {cin_c, in_a[WIDTH-1:1]};
            cout_c = in_a[0];
        end else begin
            res_c  = arith_c[WIDTH-1:0];
            cout_c = arith_c[WIDTH];
        end
    end

`ifdef ALU_PIPE_MUL_EN
    logic             mul_start_c, mul_busy_c, mul_done_c, mul_hi_nz;
    logic [WIDTH-1:0] mul_lo;
    logic             pend_cmp_q, pend_cmp_d, pend_less_q, pend_less_d;

    assign mul_start_c = accept_c && (mode == MODE_ARITH) && (select == ARI_MUL);
    assign load_c      = accept_c && !mul_start_c;
    assign busy        = mul_busy_c;

    alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start_c),
        .a          (in_a),
        .b          (in_b),
        .busy_c     (mul_busy_c),
        .done_c     (mul_done_c),
        .prod_lo    (mul_lo),
        .prod_hi_nz (mul_hi_nz)
    );

    // Compare flags of a multiply are captured at accept and shown with the product
    always_comb begin
        pend_cmp_d  = pend_cmp_q;
        pend_less_d = pend_less_q;
        if (mul_start_c) begin
            pend_cmp_d  = cmp_c;
            pend_less_d = less_c;
        end
    end

    // Pending compare flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cmp_q  <= 1'b0;
            pend_less_q <= 1'b0;
        end else begin
            pend_cmp_q  <= pend_cmp_d;
            pend_less_q <= pend_less_d;
        end
    end
`else
    assign load_c = accept_c;
    assign busy   = 1'b0;
`endif

    // Output slot: load on accept (or multiply done), clear on consume, else hold
    always_comb begin : out_next
        out_valid_d  = out_valid_q && !out_ready;
        alu_out_d    = alu_out_q;
        carry_out_d  = carry_out_q;
        compare_d    = compare_q;
        less_d       = less_q;
        zero_d       = zero_q;
        carry_flag_d = carry_flag_q;
        if (load_c) begin
            out_valid_d = 1'b1;
            alu_out_d   = res_c;
            carry_out_d = cout_c;
            compare_d   = cmp_c;
            less_d      = less_c;
            zero_d      = (res_c == '0);
            if (mode == MODE_ARITH) begin
                carry_flag_d = cout_c;
            end
        end
`ifdef ALU_PIPE_MUL_EN
        if (mul_done_c) begin
            out_valid_d  = 1'b1;
            alu_out_d    = mul_lo;
            carry_out_d  = mul_hi_nz;
            compare_d    = pend_cmp_q;
            less_d       = pend_less_q;
            zero_d       = (mul_lo == '0);
            carry_flag_d = mul_hi_nz;
        end
`endif
    end

    // Output and carry-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alu_out_q    <= '0;
            carry_out_q  <= 1'b0;
            compare_q    <= 1'b0;
            less_q       <= 1'b0;
            zero_q       <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_out_q    <= alu_out_d;
            carry_out_q  <= carry_out_d;
            compare_q    <= compare_d;
            less_q       <= less_d;
            zero_q       <= zero_d;
            carry_flag_q <= carry_flag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign carry_out = carry_out_q;
    assign compare   = compare_q;
    assign less      = less_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16, CMP_SIGNED=0); multiply checks under ALU_PIPE_MUL_EN.
module tb_alu_pipe;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, mode, carry_in, use_flag;
    logic         out_valid, out_ready, carry_out, compare, less, zero, busy;
    logic [W-1:0] in_a, in_b, alu_out;
    logic [3:0]   select;

    alu_pipe #(.WIDTH(W), .CMP_SIGNED(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .select(select), .mode(mode),
        .carry_in(carry_in), .use_flag(use_flag), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .carry_out(carry_out),
        .compare(compare), .less(less), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         eq;
        logic         lt;
        logic         z;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_flag = 1'b0;
    logic last_acc   = 1'b0;
    logic rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model, written from the function tables with wide integer arithmetic
    function automatic exp_t model(input logic m, input logic [3:0] s,
                                   input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t   e;
        longint la, lb, lc, t;
        int     kind;  // 0 add, 1 subtract, 2 already resolved
        la = longint'(a);
        lb = longint'(b);
        lc = longint'(ci);
        t = 0;
        kind = 2;
        e.c = 1'b0;
        e.r = '0;
        if (m) begin
            case (s)
                4'd0:  e.r = ~a;
                4'd1:  e.r = ~(a | b);
                4'd2:  e.r = ~a & b;
                4'd3:  e.r = 16'h0000;
                4'd4:  e.r = ~(a & b);
                4'd5:  e.r = ~b;
                4'd6:  e.r = a ^ b;
                4'd7:  e.r = a & ~b;
                4'd8:  e.r = ~a | b;
                4'd9:  e.r = ~(a ^ b);
                4'd10: e.r = b;
                4'd11: e.r = a & b;
                4'd12: e.r = 16'hFFFF;
                4'd13: e.r = a | ~b;
                4'd14: e.r = a | b;
                default: e.r = a;
            endcase
        end else begin
            case (s)
                4'd0:  begin t = la + lc;                 kind = 0; end
                4'd1:  begin t = la + lb + lc;            kind = 0; end
                4'd2:  begin t = la - lb - lc;            kind = 1; end
                4'd3:  begin t = lb - la - lc;            kind = 1; end
                4'd4:  begin t = la + la + lc;            kind = 0; end
                4'd5:  begin t = la + (la & lb) + lc;     kind = 0; end
                4'd6:  begin t = (la | lb) + (la & lb) + lc; kind = 0; end
                4'd7:  begin t = la - lc;                 kind = 1; end
                4'd8:  begin e.r = {ci, a[W-1:1]}; e.c = a[0]; end
                4'd9:  begin t = la + 1;                  kind = 0; end
                4'd10: begin t = la - 1;                  kind = 1; end
                4'd11: begin t = lb + lc;                 kind = 0; end
                4'd12: begin t = 0 - la;                  kind = 1; end
                4'd13: begin t = la + (lb ^ 64'hFFFF) + lc; kind = 0; end
                4'd14: begin t = (la & ~lb) - lc;         kind = 1; end
`ifdef ALU_PIPE_MUL_EN
                default: begin t = la * lb; e.r = t[W-1:0]; e.c = ((t >> 16) != 0); end
`else
                default: begin t = la - lc;               kind = 1; end
`endif
            endcase
            if (kind == 0) begin
                e.r = t[W-1:0];
                e.c = (t > 65535);
            end else if (kind == 1) begin
                e.r = t[W-1:0];
                e.c = (t < 0);
            end
        end
        e.eq = (a == b);
        e.lt = (a < b);
        e.z  = (e.r == 16'h0000);
        return e;
    endfunction

    function automatic logic is_mul_op(input logic m, input logic [3:0] s);
`ifdef ALU_PIPE_MUL_EN
        return (m == 1'b0) && (s == 4'd15);
`else
        return 1'b0 && m && s[0];
`endif
    endfunction

    // One clock: score consume/accept seen before the edge, check latency after it
    task automatic tick();
        logic fi, fo, ci, mul;
        exp_t e, g;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        fi  = in_valid && in_ready;
        fo  = out_valid && out_ready;
        mul = is_mul_op(mode, select);
        if (fo) begin
            check("sb_has_entry", 64'(q.size() != 0), 64'h1);
            if (q.size() != 0) begin
                g = q.pop_front();
                check("sb_alu_out", 64'(alu_out), 64'(g.r));
                check("sb_carry", 64'(carry_out), 64'(g.c));
                check("sb_compare", 64'(compare), 64'(g.eq));
                check("sb_less", 64'(less), 64'(g.lt));
                check("sb_zero", 64'(zero), 64'(g.z));
            end
        end
        if (fi) begin
            ci = use_flag ? model_flag : carry_in;
            e  = model(mode, select, in_a, in_b, ci);
            q.push_back(e);
            if (!mode) model_flag = e.c;
        end
        @(posedge clk);
        #1;
        if (fi) begin
            if (mul) check("mul_busy_after_accept", 64'(busy), 64'h1);
            else     check("one_cycle_latency", 64'(out_valid), 64'h1);
        end
        last_acc = fi;
        @(negedge clk);
    endtask

    task automatic do_op(input logic m, input logic [3:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci, input logic uf);
        mode = m; select = s; in_a = a; in_b = b; carry_in = ci; use_flag = uf;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (last_acc) break;
        end
        check("op_accepted", 64'(last_acc), 64'h1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        for (int k = 0; k < 100 && q.size() != 0; k++) tick();
        check("drain_empty", 64'(q.size()), 64'h0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; select = '0; mode = 1'b0;
        carry_in = 1'b0; use_flag = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_alu_out", 64'(alu_out), 64'h0);
        check("rst_flags", 64'({carry_out, compare, less, zero}), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);

        // Add with carry out, wraps to zero
        do_op(1'b0, 4'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("add_wrap_out", 64'(alu_out), 64'h0000);
        check("add_wrap_carry", 64'(carry_out), 64'h1);
        check("add_wrap_zero", 64'(zero), 64'h1);

        // Stored flag feeds the next add, back to back
        do_op(1'b0, 4'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(1'b0, 4'd1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("flag_chain_out", 64'(alu_out), 64'h0001);
        check("flag_chain_carry", 64'(carry_out), 64'h0);

        // Subtract underflow with unsigned compare
        do_op(1'b0, 4'd2, 16'h0003, 16'h0005, 1'b0, 1'b0);
        check("sub_out", 64'(alu_out), 64'hFFFE);
        check("sub_borrow", 64'(carry_out), 64'h1);
        check("sub_less", 64'(less), 64'h1);
        check("sub_compare", 64'(compare), 64'h0);

`ifndef ALU_PIPE_MUL_EN
        do_op(1'b0, 4'd15, 16'h0005, 16'h0000, 1'b1, 1'b0);
        check("sel15_a_minus_c", 64'(alu_out), 64'h0004);
        check("sel15_busy", 64'(busy), 64'h0);
`endif

        // Backpressure: result held, input stalled, then consume+accept with no bubble
        drain();
        out_ready = 1'b0;
        do_op(1'b1, 4'd6, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
        mode = 1'b0; select = 4'd1; in_a = 16'h1111; in_b = 16'h2222;
        carry_in = 1'b0; use_flag = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold_out", 64'(alu_out), 64'h0FF0);
            check("stall_in_ready", 64'(in_ready), 64'h0);
            check("stall_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;
        tick();
        check("no_bubble_valid", 64'(out_valid), 64'h1);
        check("no_bubble_out", 64'(alu_out), 64'h3333);
        in_valid = 1'b0;

        // Every logic function on one operand pair
        for (int s = 0; s < 16; s++) do_op(1'b1, 4'(s), 16'hC3A5, 16'h0FF0, 1'b0, 1'b0);

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pick(), pick(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();

`ifdef ALU_PIPE_MUL_EN
        // Multiply latency and result
        do_op(1'b0, 4'd15, 16'h0100, 16'h0200, 1'b0, 1'b0);
        n_busy = 0;
        for (int k = 0; k < 100 && !out_valid; k++) begin
            if (busy) n_busy++;
            tick();
        end
        check("mul_busy_cycles", 64'(n_busy), 64'd17);
        check("mul_out_valid", 64'(out_valid), 64'h1);
        check("mul_out", 64'(alu_out), 64'h0000);
        check("mul_carry", 64'(carry_out), 64'h1);
        check("mul_busy_done", 64'(busy), 64'h0);
        drain();

        // Reset in the middle of a multiply
        do_op(1'b0, 4'd15, 16'h1234, 16'h0056, 1'b0, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mul_abort_busy", 64'(busy), 64'h0);
        check("mul_abort_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        model_flag = 1'b0;
        repeat (25) tick();
        check("mul_abort_no_result", 64'(out_valid), 64'h0);
`endif

        // Reset wins over a simultaneous accept and clears the carry flag
        do_op(1'b0, 4'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        mode = 1'b1; select = 4'd10; in_a = 16'h5555; in_b = 16'h7777; in_valid = 1'b1;
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dominates_valid", 64'(out_valid), 64'h0);
        check("rst_dominates_out", 64'(alu_out), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        model_flag = 1'b0;
        do_op(1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        check("rst_clears_flag", 64'(alu_out), 64'h0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width (legal 4..64).
REQ-002 SHALL have parameter CMP_SIGNED, default 0, meaning compare/less-than treats operands as two's complement when 1.
REQ-003 SHALL have ports, clock and reset first, one per line as follows:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid&&in_ready at a rising edge
- in_a, in_b  in  WIDTH  operands
- select  in  4  function code
- mode  in  1  0 = arithmetic, 1 = logic
- carry_in  in  1  external carry/borrow
- use_flag  in  1  1 = use stored carry flag instead of carry_in
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid&&out_ready
- alu_out  out  WIDTH  result
- carry_out  out  1  carry (add) / borrow (subtract)
- compare  out  1  in_a == in_b
- less  out  1  in_a < in_b per CMP_SIGNED
- zero  out  1  alu_out == 0
- busy  out  1  multi-cycle operation in progress

Function
REQ-004 SHALL use effective cin = use_flag ? carry_flag : carry_in, sampled at accept.
REQ-005 Logic mode SHALL compute per select 0..15: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A; carry_out = 0.
REQ-006 Arithmetic mode SHALL compute per select 0..14: A+cin, A+B+cin, A-B-cin, B-A-cin, A+A+cin, A+(A&B)+cin, (A|B)+(A&B)+cin, A-cin, {cin,A[WIDTH-1:1]} (carry_out=A[0]), A+1, A-1, B+cin, 0-A, A+~B+cin, (A&~B)-cin.
REQ-007 Additions SHALL produce carry_out = bit WIDTH of a WIDTH+1-bit sum; subtractions SHALL produce carry_out = 1 on unsigned underflow; results truncate modulo 2^WIDTH.
REQ-008 Single-cycle ops SHALL be accepted at edge N and presented with out_valid=1 after edge N; all outputs SHALL stay stable while out_valid&&!out_ready.
REQ-009 in_ready SHALL equal !busy && (!out_valid || out_ready), permitting back-to-back throughput of one op per cycle.
REQ-010 carry_flag SHALL update to carry_out on every accepted arithmetic op and hold on logic ops.
REQ-011 compare, less and zero SHALL be registered alongside alu_out for every op.
REQ-012 Simultaneous consume and accept SHALL replace the result with no bubble; out_valid stays 1.

Reset
REQ-013 On rst: out_valid=0, busy=0, alu_out=0, carry_out=0, compare=0, less=0, zero=0, carry_flag=0, multiplier FSM to IDLE.
REQ-014 rst during a multiply SHALL abort it with no result produced; rst dominates accept.

Configuration
REQ-015 With ALU_PIPE_MUL_EN defined, arithmetic select 15 SHALL be unsigned A*B: low WIDTH bits on alu_out, carry_out = OR of high WIDTH bits, computed by shift-add FSM IDLE->MUL (WIDTH cycles)->DONE->IDLE; busy=1 in MUL/DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-016 Without ALU_PIPE_MUL_EN, arithmetic select 15 SHALL be A-cin single-cycle and busy SHALL be constant 0.

Structure
REQ-017 Package alu_pipe_pkg SHALL hold mode constants, logic and arithmetic select codes, and the multiplier FSM state type.
REQ-018 The multiplier SHALL be sub-module alu_pipe_mul, instantiated only under ALU_PIPE_MUL_EN.

Verification (WIDTH=16)
REQ-019 Arith select 1, A=FFFF, B=0001, cin=0 -> alu_out=0000, carry_out=1, zero=1, one cycle latency.
REQ-020 Chain: select 1, A=FFFF, B=0001, then select 1, A=0000, B=0000, use_flag=1 -> second alu_out=0001.
REQ-021 Logic select 6, A=F0F0, B=FF00 with out_ready=0 for 3 cycles -> alu_out=0F F0 (0FF0) held stable, in_ready=0, no loss.
REQ-022 Arith select 2, A=0003, B=0005, CMP_SIGNED=0 -> alu_out=FFFE, carry_out=1, less=1, compare=0.
REQ-023 ALU_PIPE_MUL_EN: select 15, A=0100, B=0200 -> busy 17 cycles, alu_out=0000, carry_out=1; rst asserted mid-MUL -> out_valid stays 0, busy=0 next cycle.
